// File: rtl/fetch_target_queue.sv
// Fetch target queue: a circular buffer of predicted fetch blocks between the branch
// predictor and the icache. Each entry holds a start PC and an instruction count, and
// the head entry is presented with its fall-through address.
module fetch_target_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_start_addr,
  input  logic [1:0]        in_fetch_num,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_start_addr,
  output logic [1:0]        out_fetch_num,
  output logic [31:0]       out_next_addr,
  output logic [PTR_W-1:0]  out_ftq_id,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Fall-through PC of a block: 4 bytes per instruction, wrapping at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [1:0] num);
    return pc + {28'd0, num, 2'b00} + 32'd4;
  endfunction

  logic [31:0]      slot_addr_q [DEPTH];
  logic [1:0]       slot_num_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             enq, deq;

  assign in_ready       = (count_q != FULL_CNT);
  assign out_valid      = (count_q != '0);
  assign out_start_addr = slot_addr_q[rd_ptr_q];
  assign out_fetch_num  = slot_num_q[rd_ptr_q];
  assign out_next_addr  = next_pc(out_start_addr, out_fetch_num);
  assign out_ftq_id     = rd_ptr_q;
  assign count          = count_q;

  always_comb begin
    enq      = in_valid && in_ready && !flush;
    deq      = out_valid && out_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointer width equals log2(DEPTH), so natural overflow is the modulo wrap.
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot payload is never cleared; it is only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (enq) begin
      slot_addr_q[wr_ptr_q] <= in_start_addr;
      slot_num_q[wr_ptr_q]  <= in_fetch_num;
    end
  end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: a vector table for the basic flows plus
// hand-written fill/full/drain sequences.
module tb_fetch_target_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_start_addr;
  logic [1:0]  in_fetch_num;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_start_addr;
  logic [1:0]  out_fetch_num;
  logic [31:0] out_next_addr;
  logic [2:0]  out_ftq_id;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fetch_target_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_start_addr(in_start_addr), .in_fetch_num(in_fetch_num),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_start_addr(out_start_addr), .out_fetch_num(out_fetch_num),
    .out_next_addr(out_next_addr), .out_ftq_id(out_ftq_id),
    .count(count)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic [1:0]  inum;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [3:0]  e_cnt;
    logic [2:0]  e_id;
    logic        chk_head;
    logic [31:0] e_sa;
    logic [1:0]  e_num;
    logic [31:0] e_na;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                       input logic [1:0] n, input logic fl, input logic ordy);
    rst = r; in_valid = iv; in_start_addr = ia; in_fetch_num = n;
    flush = fl; out_ready = ordy;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic ov, input logic ir,
                             input logic [3:0] c, input logic [2:0] id);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, "_in_ready"},  32'(in_ready),  32'(ir));
    check({tag, "_count"},     32'(count),     32'(c));
    check({tag, "_ftq_id"},    32'(out_ftq_id), 32'(id));
  endtask

  task automatic check_head(input string tag, input logic [31:0] sa,
                            input logic [1:0] n, input logic [31:0] na);
    check({tag, "_start"}, out_start_addr, sa);
    check({tag, "_num"},   32'(out_fetch_num), 32'(n));
    check({tag, "_next"},  out_next_addr, na);
  endtask

  function automatic logic [31:0] fill_pc(input int j);
    return 32'h1000_0000 + 32'(j) * 32'h40;
  endfunction

  initial begin
    //          rst   iv    ia            num   fl    rdy     ov    ir    cnt    id    chk   start         num   next
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0,  1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1C000000, 2'd3, 1'b0, 1'b1,  1'b1, 1'b1, 4'd1, 3'd0, 1'b1, 32'h1C000000, 2'd3, 32'h1C000010};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1,  1'b0, 1'b1, 4'd0, 3'd1, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFF8, 2'd1, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 3'd1, 1'b1, 32'hFFFFFFF8, 2'd1, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1,  1'b0, 1'b1, 4'd0, 3'd2, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h100,      2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 3'd2, 1'b1, 32'h100,      2'd0, 32'h104};
    vecs[6]  = '{1'b0, 1'b1, 32'h200,      2'd1, 1'b0, 1'b0,  1'b1, 1'b1, 4'd2, 3'd2, 1'b1, 32'h100,      2'd0, 32'h104};
    vecs[7]  = '{1'b0, 1'b1, 32'h300,      2'd2, 1'b0, 1'b0,  1'b1, 1'b1, 4'd3, 3'd2, 1'b1, 32'h100,      2'd0, 32'h104};
    vecs[8]  = '{1'b0, 1'b1, 32'h400,      2'd3, 1'b0, 1'b0,  1'b1, 1'b1, 4'd4, 3'd2, 1'b1, 32'h100,      2'd0, 32'h104};
    vecs[9]  = '{1'b0, 1'b1, 32'h500,      2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 4'd5, 3'd2, 1'b1, 32'h100,      2'd0, 32'h104};
    vecs[10] = '{1'b0, 1'b1, 32'h600,      2'd2, 1'b1, 1'b1,  1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h2000,     2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 3'd0, 1'b1, 32'h2000,     2'd0, 32'h2004};
    vecs[12] = '{1'b0, 1'b1, 32'h3000,     2'd1, 1'b0, 1'b0,  1'b1, 1'b1, 4'd2, 3'd0, 1'b1, 32'h2000,     2'd0, 32'h2004};
    vecs[13] = '{1'b0, 1'b1, 32'h4000,     2'd2, 1'b0, 1'b0,  1'b1, 1'b1, 4'd3, 3'd0, 1'b1, 32'h2000,     2'd0, 32'h2004};
    vecs[14] = '{1'b0, 1'b1, 32'h5000,     2'd3, 1'b0, 1'b1,  1'b1, 1'b1, 4'd3, 3'd1, 1'b1, 32'h3000,     2'd1, 32'h3008};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 4'd2, 3'd2, 1'b1, 32'h4000,     2'd2, 32'h400C};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 4'd1, 3'd3, 1'b1, 32'h5000,     2'd3, 32'h5010};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b0, 1'b1,  1'b0, 1'b1, 4'd0, 3'd4, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 32'h6000,     2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 3'd4, 1'b1, 32'h6000,     2'd0, 32'h6004};
    vecs[19] = '{1'b1, 1'b1, 32'h6100,     2'd0, 1'b0, 1'b0,  1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 32'h0,        2'd0, 32'h0};
    vecs[20] = '{1'b0, 1'b1, 32'h7000,     2'd1, 1'b0, 1'b0,  1'b1, 1'b1, 4'd1, 3'd0, 1'b1, 32'h7000,     2'd1, 32'h7008};
    vecs[21] = '{1'b1, 1'b0, 32'h0,        2'd0, 1'b0, 1'b0,  1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 32'h0,        2'd0, 32'h0};

    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].inum, vecs[i].fl, vecs[i].ordy);
      step();
      check_state($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt, vecs[i].e_id);
      if (vecs[i].chk_head)
        check_head($sformatf("v%0d", i), vecs[i].e_sa, vecs[i].e_num, vecs[i].e_na);
    end

    // Fill to full with the consumer stalled; the head must hold entry 0 throughout.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, fill_pc(i), 2'(i), 1'b0, 1'b0);
      step();
      check_state($sformatf("fill%0d", i), 1'b1, (i != 7), 4'(i + 1), 3'd0);
      check_head($sformatf("fill%0d", i), fill_pc(0), 2'd0, fill_pc(0) + 32'd4);
    end

    // Ninth offer while full is refused.
    drive(1'b0, 1'b1, 32'hDEAD0000, 2'd3, 1'b0, 1'b0);
    step();
    check_state("over", 1'b1, 1'b0, 4'd8, 3'd0);
    check_head("over", fill_pc(0), 2'd0, fill_pc(0) + 32'd4);

    // Full with simultaneous offer and accept: only the dequeue happens.
    drive(1'b0, 1'b1, 32'hBEEF0000, 2'd2, 1'b0, 1'b1);
    step();
    check_state("fulldq", 1'b1, 1'b1, 4'd7, 3'd1);
    check_head("fulldq", fill_pc(1), 2'd1, fill_pc(1) + 32'd8);

    // Drain the rest in order; the read pointer wraps back to 0.
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      step();
      check_state($sformatf("drain%0d", k), (k != 7), 1'b1, 4'(7 - k), 3'((k + 1) % 8));
      if (k != 7)
        check_head($sformatf("drain%0d", k), fill_pc(k + 1), 2'((k + 1) % 4),
                   fill_pc(k + 1) + 32'(4 * ((k + 1) % 4 + 1)));
    end

    // Write pointer has wrapped too: the next entry lands in slot 0.
    drive(1'b0, 1'b1, 32'h8000, 2'd0, 1'b0, 1'b0);
    step();
    check_state("wrap", 1'b1, 1'b1, 4'd1, 3'd0);
    check_head("wrap", 32'h8000, 2'd0, 32'h8004);

    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
